// File: rtl/cpu_bus_pkg.sv
// Shared definitions for the CPU-side sram bus: requester owner tags,
// access size encodings and the request lock state.
package cpu_bus_pkg;

    localparam logic OWNER_INST = 1'b0;
    localparam logic OWNER_DATA = 1'b1;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    typedef enum logic {
        LOCK_IDLE = 1'b0,
        LOCK_HELD = 1'b1
    } lock_state_e;

endpackage

// File: rtl/owner_fifo.sv
// In-order FIFO of 1-bit owner tags, one entry per outstanding downstream
// transaction; head names the requester that owns the next response.
module owner_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       push,
    input  logic                       push_owner,
    input  logic                       pop,
    output logic                       head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DEPTH-1:0] slots_q, slots_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign head    = slots_q[rd_ptr_q];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        slots_d  = slots_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            slots_d[wr_ptr_q] = push_owner;
            wr_ptr_d          = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            slots_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            slots_q  <= slots_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one sram-like downstream port between instruction fetch and data
// access, keeping responses in order and routing each to its requester.
module sram_port_arbiter
    import cpu_bus_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MAX_OUT     = 4,
    parameter int DATA_STREAK = 4
) (
    input  logic              clk,
    input  logic              resetn,

    input  logic              inst_req,
    input  logic              inst_wr,
    input  logic [1:0]        inst_size,
    input  logic [ADDR_W-1:0] inst_addr,
    input  logic [DATA_W-1:0] inst_wdata,
    output logic              inst_addr_ok,
    output logic              inst_data_ok,
    output logic [DATA_W-1:0] inst_rdata,

    input  logic              data_req,
    input  logic              data_wr,
    input  logic [1:0]        data_size,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic              data_addr_ok,
    output logic              data_data_ok,
    output logic [DATA_W-1:0] data_rdata,

    output logic              mem_req,
    output logic              mem_wr,
    output logic [1:0]        mem_size,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_addr_ok,
    input  logic              mem_data_ok,
    input  logic [DATA_W-1:0] mem_rdata,

    output logic              busy,
    output logic              err_unexp_resp
);

    localparam int CNT_W    = $clog2(MAX_OUT) + 1;
    localparam int STREAK_W = $clog2(DATA_STREAK + 1);

    lock_state_e         lock_state_q, lock_state_d;
    logic                lock_owner_q, lock_owner_d;
    logic [STREAK_W-1:0] streak_q, streak_d;
    logic                err_q, err_d;

    logic                winner;
    logic                grant_req;
    logic                streak_at_max;
    logic                accept;
    logic                pop;
    logic                fifo_head;
    logic                fifo_full;
    logic                fifo_empty;
    logic [CNT_W-1:0]    fifo_count;

    assign streak_at_max = (streak_q == STREAK_W'(DATA_STREAK));

    // A held request keeps its owner; otherwise data wins unless starving inst.
    always_comb begin
        winner = OWNER_DATA;
        if (lock_state_q == LOCK_HELD) begin
            winner = lock_owner_q;
        end else if (data_req && !(inst_req && streak_at_max)) begin
            winner = OWNER_DATA;
        end else if (inst_req) begin
            winner = OWNER_INST;
        end
    end

    assign grant_req = (winner == OWNER_DATA) ? data_req : inst_req;
    assign mem_req   = resetn & ~fifo_full & grant_req;
    assign mem_wr    = (winner == OWNER_DATA) ? data_wr    : inst_wr;
    assign mem_size  = (winner == OWNER_DATA) ? data_size  : inst_size;
    assign mem_addr  = (winner == OWNER_DATA) ? data_addr  : inst_addr;
    assign mem_wdata = (winner == OWNER_DATA) ? data_wdata : inst_wdata;

    assign accept       = mem_req & mem_addr_ok;
    assign inst_addr_ok = accept & (winner == OWNER_INST);
    assign data_addr_ok = accept & (winner == OWNER_DATA);

    assign pop          = resetn & mem_data_ok & ~fifo_empty;
    assign inst_data_ok = pop & (fifo_head == OWNER_INST);
    assign data_data_ok = pop & (fifo_head == OWNER_DATA);
    assign inst_rdata   = mem_rdata;
    assign data_rdata   = mem_rdata;

    assign busy           = (fifo_count != '0);
    assign err_unexp_resp = err_q;

    owner_fifo #(
        .DEPTH (MAX_OUT)
    ) u_owner_fifo (
        .clk        (clk),
        .resetn     (resetn),
        .push       (accept),
        .push_owner (winner),
        .pop        (pop),
        .head       (fifo_head),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .count      (fifo_count)
    );

    always_comb begin
        lock_state_d = lock_state_q;
        lock_owner_d = lock_owner_q;
        case (lock_state_q)
            LOCK_IDLE: begin
                if (mem_req && !mem_addr_ok) begin
                    lock_state_d = LOCK_HELD;
                    lock_owner_d = winner;
                end
            end
            LOCK_HELD: begin
                if (mem_addr_ok) begin
                    lock_state_d = LOCK_IDLE;
                end
            end
            default: lock_state_d = LOCK_IDLE;
        endcase
    end

    // The streak only measures how long inst has been kept waiting.
    always_comb begin
        streak_d = streak_q;
        if (!inst_req) begin
            streak_d = '0;
        end else if (accept && winner == OWNER_INST) begin
            streak_d = '0;
        end else if (accept && !streak_at_max) begin
            streak_d = streak_q + STREAK_W'(1);
        end
    end

    assign err_d = err_q | (mem_data_ok & fifo_empty);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lock_state_q <= LOCK_IDLE;
            lock_owner_q <= OWNER_INST;
            streak_q     <= '0;
            err_q        <= 1'b0;
        end else begin
            lock_state_q <= lock_state_d;
            lock_owner_q <= lock_owner_d;
            streak_q     <= streak_d;
            err_q        <= err_d;
        end
    end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Self-checking bench for sram_port_arbiter: directed scenarios plus a random
// run compared against a queue-based reference model of the arbitration rules.
module tb_sram_port_arbiter;

    localparam int ADDR_W      = 32;
    localparam int DATA_W      = 32;
    localparam int MAX_OUT     = 4;
    localparam int DATA_STREAK = 4;

    logic              clk = 1'b0;
    logic              resetn;
    logic              inst_req, inst_wr;
    logic [1:0]        inst_size;
    logic [ADDR_W-1:0] inst_addr;
    logic [DATA_W-1:0] inst_wdata;
    logic              inst_addr_ok, inst_data_ok;
    logic [DATA_W-1:0] inst_rdata;
    logic              data_req, data_wr;
    logic [1:0]        data_size;
    logic [ADDR_W-1:0] data_addr;
    logic [DATA_W-1:0] data_wdata;
    logic              data_addr_ok, data_data_ok;
    logic [DATA_W-1:0] data_rdata;
    logic              mem_req, mem_wr;
    logic [1:0]        mem_size;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_addr_ok, mem_data_ok;
    logic [DATA_W-1:0] mem_rdata;
    logic              busy, err_unexp_resp;

    int total = 0;
    int bad   = 0;

    // Reference model state: queue of outstanding owners (0=inst, 1=data).
    bit own_q[$];
    int streak_m;
    bit locked_m;
    bit lock_own_m;
    bit err_m;

    always #5 clk = ~clk;

    sram_port_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_OUT(MAX_OUT), .DATA_STREAK(DATA_STREAK)
    ) dut (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
        .inst_addr(inst_addr), .inst_wdata(inst_wdata),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
        .busy(busy), .err_unexp_resp(err_unexp_resp)
    );

    function automatic bit m_winner();
        if (locked_m) return lock_own_m;
        if (data_req && !(inst_req && streak_m == DATA_STREAK)) return 1'b1;
        if (inst_req) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit m_mem_req();
        return resetn && (own_q.size() < MAX_OUT) && (m_winner() ? data_req : inst_req);
    endfunction

    function automatic bit m_accept(input bit who);
        return m_mem_req() && mem_addr_ok && (m_winner() == who);
    endfunction

    function automatic bit m_resp(input bit who);
        return resetn && mem_data_ok && (own_q.size() > 0) && (own_q[0] == who);
    endfunction

    task automatic model_reset();
        own_q.delete();
        streak_m   = 0;
        locked_m   = 0;
        lock_own_m = 0;
        err_m      = 0;
    endtask

    task automatic model_tick();
        bit acc, w, req;
        w   = m_winner();
        req = m_mem_req();
        acc = req && mem_addr_ok;
        if (mem_data_ok) begin
            if (own_q.size() > 0) void'(own_q.pop_front());
            else err_m = 1;
        end
        if (acc) own_q.push_back(w);
        if (!inst_req) streak_m = 0;
        else if (acc && !w) streak_m = 0;
        else if (acc && w && streak_m < DATA_STREAK) streak_m++;
        if (!locked_m && req && !mem_addr_ok) begin
            locked_m   = 1;
            lock_own_m = w;
        end else if (locked_m && mem_addr_ok) begin
            locked_m = 0;
        end
    endtask

    task automatic settle();
        #4;
    endtask

    task automatic advance();
        @(posedge clk);
        if (resetn) model_tick();
        else model_reset();
        #1;
    endtask

    task automatic drain();
        inst_req = 0;
        data_req = 0;
        mem_addr_ok = 0;
        for (int i = 0; i < 16 && own_q.size() > 0; i++) begin
            mem_data_ok = 1;
            mem_rdata   = $urandom;
            settle();
            advance();
        end
        mem_data_ok = 0;
    endtask

    task automatic test_reset();
        resetn = 0;
        {inst_req, inst_wr, inst_size, inst_addr, inst_wdata} = '0;
        {data_req, data_wr, data_size, data_addr, data_wdata} = '0;
        {mem_addr_ok, mem_data_ok, mem_rdata} = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        inst_req = 1; data_req = 1; mem_addr_ok = 1; mem_data_ok = 1;
        settle();
        total++;
        if ({mem_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok, busy, err_unexp_resp} !== 7'b0) begin
            bad++;
            $display("[TB] FAIL reset_outputs: got %b want 0000000",
                     {mem_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok, busy, err_unexp_resp});
        end
        inst_req = 0; data_req = 0; mem_addr_ok = 0; mem_data_ok = 0;
        @(posedge clk);
        #1;
        resetn = 1;
        settle();
        total++;
        if ({mem_req, busy, err_unexp_resp} !== 3'b0) begin
            bad++;
            $display("[TB] FAIL after_reset: got %b want 000", {mem_req, busy, err_unexp_resp});
        end
        advance();
    endtask

    task automatic test_single_read();
        inst_req = 1; inst_addr = 32'h1FC0_0000; inst_size = 2'd2; mem_addr_ok = 1;
        settle();
        total++;
        if ({inst_addr_ok, data_addr_ok, mem_req} !== 3'b101) begin
            bad++;
            $display("[TB] FAIL single_accept: got %b want 101", {inst_addr_ok, data_addr_ok, mem_req});
        end
        total++;
        if (mem_addr !== 32'h1FC0_0000) begin
            bad++;
            $display("[TB] FAIL single_addr: got %h want 1fc00000", mem_addr);
        end
        advance();
        inst_req = 0;
        settle();
        total++;
        if ({inst_addr_ok, busy} !== 2'b01) begin
            bad++;
            $display("[TB] FAIL single_wait: got %b want 01", {inst_addr_ok, busy});
        end
        advance();
        mem_data_ok = 1; mem_rdata = 32'h2408_0001;
        settle();
        total++;
        if ({inst_data_ok, data_data_ok} !== 2'b10 || inst_rdata !== 32'h2408_0001) begin
            bad++;
            $display("[TB] FAIL single_resp: got ok=%b rdata=%h want ok=10 rdata=24080001",
                     {inst_data_ok, data_data_ok}, inst_rdata);
        end
        advance();
        mem_data_ok = 0; mem_addr_ok = 0;
        settle();
        total++;
        if ({inst_data_ok, busy} !== 2'b00) begin
            bad++;
            $display("[TB] FAIL single_idle: got %b want 00", {inst_data_ok, busy});
        end
        advance();
    endtask

    task automatic test_contention();
        bit exp_data [10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
        inst_req = 1; data_req = 1; mem_addr_ok = 1;
        inst_addr = 32'h1FC0_0100; data_addr = 32'h0000_2000;
        for (int i = 0; i < 10; i++) begin
            mem_data_ok = (i > 0);
            mem_rdata   = $urandom;
            settle();
            total++;
            if ({inst_addr_ok, data_addr_ok} !== {!exp_data[i], exp_data[i]}) begin
                bad++;
                $display("[TB] FAIL contention_grant%0d: got inst=%b data=%b want inst=%b data=%b",
                         i, inst_addr_ok, data_addr_ok, !exp_data[i], exp_data[i]);
            end
            advance();
        end
        drain();
    endtask

    task automatic test_backpressure();
        data_req = 1; data_wr = 1; data_size = 2'd2;
        data_addr = 32'h8000_0010; data_wdata = 32'hDEAD_BEEF;
        mem_addr_ok = 0;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) begin
                inst_req = 1; inst_addr = 32'h1FC0_0004;
            end
            settle();
            total++;
            if ({mem_req, inst_addr_ok, data_addr_ok} !== 3'b100 ||
                mem_addr !== 32'h8000_0010 || mem_wdata !== 32'hDEAD_BEEF) begin
                bad++;
                $display("[TB] FAIL bp_hold%0d: got req/ok=%b addr=%h wdata=%h want 100 80000010 deadbeef",
                         i, {mem_req, inst_addr_ok, data_addr_ok}, mem_addr, mem_wdata);
            end
            advance();
        end
        mem_addr_ok = 1;
        settle();
        total++;
        if ({inst_addr_ok, data_addr_ok} !== 2'b01) begin
            bad++;
            $display("[TB] FAIL bp_data_accept: got %b want 01", {inst_addr_ok, data_addr_ok});
        end
        advance();
        data_req = 0;
        settle();
        total++;
        if ({inst_addr_ok, data_addr_ok} !== 2'b10) begin
            bad++;
            $display("[TB] FAIL bp_inst_after: got %b want 10", {inst_addr_ok, data_addr_ok});
        end
        advance();
        drain();
        // Inst locked first; a later data request must not steal the port.
        inst_req = 1; inst_addr = 32'h1FC0_0040; mem_addr_ok = 0;
        settle();
        advance();
        data_req = 1; data_addr = 32'h0000_3000;
        settle();
        total++;
        if (mem_addr !== 32'h1FC0_0040) begin
            bad++;
            $display("[TB] FAIL lock_inst_addr: got %h want 1fc00040", mem_addr);
        end
        advance();
        mem_addr_ok = 1;
        settle();
        total++;
        if ({inst_addr_ok, data_addr_ok} !== 2'b10) begin
            bad++;
            $display("[TB] FAIL lock_inst_accept: got %b want 10", {inst_addr_ok, data_addr_ok});
        end
        advance();
        inst_req = 0;
        settle();
        advance();
        drain();
    endtask

    task automatic test_full_fifo();
        data_req = 1; data_wr = 0; mem_addr_ok = 1; mem_data_ok = 0;
        for (int i = 0; i < 4; i++) begin
            data_addr = 32'h0000_4000 + 32'(i * 4);
            settle();
            total++;
            if (data_addr_ok !== 1'b1) begin
                bad++;
                $display("[TB] FAIL full_fill%0d: got %b want 1", i, data_addr_ok);
            end
            advance();
        end
        data_addr = 32'h0000_4010;
        mem_data_ok = 1; mem_rdata = 32'h0BAD_F00D;
        settle();
        total++;
        if ({mem_req, data_addr_ok, data_data_ok} !== 3'b001) begin
            bad++;
            $display("[TB] FAIL full_stall: got %b want 001", {mem_req, data_addr_ok, data_data_ok});
        end
        advance();
        mem_data_ok = 0;
        settle();
        total++;
        if (data_addr_ok !== 1'b1) begin
            bad++;
            $display("[TB] FAIL full_resume: got %b want 1", data_addr_ok);
        end
        advance();
        drain();
    endtask

    task automatic test_ordering();
        bit exp_own [3] = '{0, 1, 0};
        mem_addr_ok = 1;
        for (int i = 0; i < 3; i++) begin
            inst_req = !exp_own[i]; data_req = exp_own[i];
            settle();
            advance();
        end
        inst_req = 0; data_req = 0; mem_addr_ok = 0;
        for (int i = 0; i < 3; i++) begin
            mem_data_ok = 1;
            mem_rdata   = 32'h1111_1111 * 32'(i + 1);
            settle();
            total++;
            if ({inst_data_ok, data_data_ok} !== {!exp_own[i], exp_own[i]} ||
                (exp_own[i] ? data_rdata : inst_rdata) !== 32'h1111_1111 * 32'(i + 1)) begin
                bad++;
                $display("[TB] FAIL order_resp%0d: got ok=%b rdata=%h want ok=%b rdata=%h",
                         i, {inst_data_ok, data_data_ok}, exp_own[i] ? data_rdata : inst_rdata,
                         {!exp_own[i], exp_own[i]}, 32'h1111_1111 * 32'(i + 1));
            end
            advance();
        end
        mem_data_ok = 0;
        settle();
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL order_busy: got %b want 0", busy);
        end
        advance();
    endtask

    task automatic test_random();
        bit acc_i, acc_d, w;
        inst_req = 0; data_req = 0;
        for (int c = 0; c < 400; c++) begin
            if (!inst_req && $urandom_range(0, 1)) begin
                inst_req = 1; inst_wr = 0; inst_size = 2'($urandom_range(0, 2));
                inst_addr = $urandom; inst_wdata = $urandom;
            end
            if (!data_req && $urandom_range(0, 2) != 0) begin
                data_req = 1; data_wr = 1'($urandom); data_size = 2'($urandom_range(0, 2));
                data_addr = $urandom; data_wdata = $urandom;
            end
            mem_addr_ok = ($urandom_range(0, 3) != 0);
            mem_data_ok = (own_q.size() > 0) && ($urandom_range(0, 1) == 1);
            mem_rdata   = $urandom;
            settle();
            w     = m_winner();
            acc_i = m_accept(1'b0);
            acc_d = m_accept(1'b1);
            total++;
            if ({mem_req, inst_addr_ok, data_addr_ok} !== {m_mem_req(), acc_i, acc_d}) begin
                bad++;
                $display("[TB] FAIL rand_grant c%0d: got %b want %b",
                         c, {mem_req, inst_addr_ok, data_addr_ok}, {m_mem_req(), acc_i, acc_d});
            end
            total++;
            if ({inst_data_ok, data_data_ok} !== {m_resp(1'b0), m_resp(1'b1)}) begin
                bad++;
                $display("[TB] FAIL rand_resp c%0d: got %b want %b",
                         c, {inst_data_ok, data_data_ok}, {m_resp(1'b0), m_resp(1'b1)});
            end
            total++;
            if (busy !== (own_q.size() != 0) || inst_rdata !== mem_rdata || data_rdata !== mem_rdata) begin
                bad++;
                $display("[TB] FAIL rand_busy_rdata c%0d: got busy=%b rdata=%h/%h want busy=%b rdata=%h",
                         c, busy, inst_rdata, data_rdata, own_q.size() != 0, mem_rdata);
            end
            if (m_mem_req()) begin
                total++;
                if ({mem_wr, mem_size, mem_addr, mem_wdata} !==
                    (w ? {data_wr, data_size, data_addr, data_wdata}
                       : {inst_wr, inst_size, inst_addr, inst_wdata})) begin
                    bad++;
                    $display("[TB] FAIL rand_fields c%0d: got addr=%h want owner=%b", c, mem_addr, w);
                end
            end
            advance();
            if (acc_i) inst_req = 0;
            if (acc_d) data_req = 0;
        end
        drain();
    endtask

    task automatic test_errors();
        mem_data_ok = 1;
        settle();
        total++;
        if ({inst_data_ok, data_data_ok, err_unexp_resp} !== 3'b000) begin
            bad++;
            $display("[TB] FAIL err_ignore: got %b want 000", {inst_data_ok, data_data_ok, err_unexp_resp});
        end
        advance();
        mem_data_ok = 0;
        for (int i = 0; i < 3; i++) begin
            settle();
            total++;
            if (err_unexp_resp !== err_m || err_m !== 1'b1) begin
                bad++;
                $display("[TB] FAIL err_sticky%0d: got %b want 1", i, err_unexp_resp);
            end
            advance();
        end
        data_req = 1; mem_addr_ok = 1;
        repeat (2) begin
            settle();
            advance();
        end
        inst_req = 1; mem_data_ok = 1;
        #2;
        resetn = 0;
        #1;
        model_reset();
        total++;
        if ({mem_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok, busy, err_unexp_resp} !== 7'b0) begin
            bad++;
            $display("[TB] FAIL async_reset: got %b want 0000000",
                     {mem_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok, busy, err_unexp_resp});
        end
        inst_req = 0; data_req = 0; mem_addr_ok = 0; mem_data_ok = 0;
        advance();
        resetn = 1;
        settle();
        total++;
        if ({busy, err_unexp_resp} !== 2'b00) begin
            bad++;
            $display("[TB] FAIL reset_empty: got %b want 00", {busy, err_unexp_resp});
        end
        advance();
        mem_data_ok = 1;
        settle();
        advance();
        mem_data_ok = 0;
        settle();
        total++;
        if (err_unexp_resp !== 1'b1) begin
            bad++;
            $display("[TB] FAIL late_resp_err: got %b want 1", err_unexp_resp);
        end
        advance();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_contention();
        test_backpressure();
        test_full_fifo();
        test_ordering();
        test_random();
        test_errors();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
